key_encoder_5_to_3: RTL and testbench

- Input-side counterpart of the 5-line one-hot position decoder: converts 5 raw stopwatch keys into a registered 3-bit key index.
- Key 0 is start/stop, 1 is lap, 2 is reset, 3 is mode and 4 is set.
- Synchronises and debounces the keys, encodes the press, and emits a one-cycle valid strobe per press.
- Sits between the board buttons and the stopwatch control FSM.

---
 rtl/key_pkg.sv | 37 +++
 rtl/key_encoder_5_to_3_if.sv | 14 +
 rtl/sync_2ff.sv | 27 ++
 rtl/key_encoder_5_to_3.sv | 149 ++++++++++++++
 tb/tb_key_encoder_5_to_3.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared constants for the stopwatch key encoder: FSM encoding, key indices,
// widths and the press-encoding helper.
package key_pkg;

  localparam int KEY_W  = 5;
  localparam int CODE_W = 3;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [CODE_W-1:0] KEY_START = 3'd0;
  localparam logic [CODE_W-1:0] KEY_LAP   = 3'd1;
  localparam logic [CODE_W-1:0] KEY_RESET = 3'd2;
  localparam logic [CODE_W-1:0] KEY_MODE  = 3'd3;
  localparam logic [CODE_W-1:0] KEY_SET   = 3'd4;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              multi;
  } key_enc_t;

  // Lowest-numbered key wins; multi flags a chord of two or more keys.
  function automatic key_enc_t encode_keys(input logic [KEY_W-1:0] sample);
    key_enc_t enc;
    if (sample[0])      enc.code = KEY_START;
    else if (sample[1]) enc.code = KEY_LAP;
    else if (sample[2]) enc.code = KEY_RESET;
    else if (sample[3]) enc.code = KEY_MODE;
    else if (sample[4]) enc.code = KEY_SET;
    else                enc.code = KEY_START;
    enc.multi = ($countones(sample) > 1);
    return enc;
  endfunction

endpackage

// File: rtl/key_encoder_5_to_3_if.sv
// Key-side bus of the encoder: raw key levels in, encoded press out.
interface key_encoder_5_to_3_if;
  import key_pkg::*;

  logic [KEY_W-1:0]  keys;
  logic [CODE_W-1:0] code;
  logic              multi;
  logic              valid;
  logic              held;

  modport master (output keys, input code, multi, valid, held);
  modport slave  (input keys, output code, multi, valid, held);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with synchronous
// clear so a reset also flushes any key level in flight.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_encoder_5_to_3.sv
// Debounces five stopwatch keys and emits a registered key index with a
// one-cycle valid per press. Optional macro AUTO_REPEAT_EN adds auto-repeat.
module key_encoder_5_to_3
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic               clk,
  input logic               rst,
  key_encoder_5_to_3_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0] ks;
  logic [1:0]       state_q, state_d;
  logic [KEY_W-1:0] sample_q, sample_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  key_enc_t         enc_q, enc_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
`endif

  sync_2ff #(.WIDTH(KEY_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.keys),
    .q_o (ks)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cnt_d    = cnt_q;
    enc_d    = enc_q;
    valid_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif

    case (state_q)
      IDLE: begin
        if (ks != '0) begin
          sample_d = ks;
          cnt_d    = '0;
          state_d  = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (ks == '0) begin
          state_d = IDLE;
        end else if (ks != sample_q) begin
          sample_d = ks;
          cnt_d    = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          enc_d   = encode_keys(sample_q);
          valid_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Key changes during a press are ignored; only a full release ends it.
      PRESSED: begin
        if (ks == '0) begin
          cnt_d   = '0;
          state_d = RELEASE;
`ifdef AUTO_REPEAT_EN
          rep_d = '0;
`endif
        end else begin
`ifdef AUTO_REPEAT_EN
          if ((rep_first_q && rep_q == REP_DELAY_LAST) ||
              (!rep_first_q && rep_q == REP_PERIOD_LAST)) begin
            valid_d     = 1'b1;
            rep_d       = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_d = rep_q + 1'b1;
          end
`endif
        end
      end
      RELEASE: begin
        if (ks != '0) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      cnt_q    <= '0;
      enc_q    <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      enc_q    <= enc_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q       <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  assign bus.code  = enc_q.code;
  assign bus.multi = enc_q.multi;
  assign bus.valid = valid_q;
  assign bus.held  = held_q;

endmodule

// File: tb/tb_key_encoder_5_to_3.sv
// Self-checking bench for key_encoder_5_to_3: vector table, hand-written
// corner sequences and random keys checked against a timestamp-based model.
module tb_key_encoder_5_to_3;
  import key_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_encoder_5_to_3_if bus();

  key_encoder_5_to_3 #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (20),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int edgeNo     = 0;

  // Model: synchroniser delay plus timestamps of when the observed key
  // vector last changed, when a release last restarted, and press age.
  logic [4:0] mS1, mKs, mPrev;
  int         mRunStart, mRelMark, mSincePress;
  int         mPhase;
  logic       eValid, eHeld, eMulti, prevValid;
  logic [2:0] eCode;

  typedef struct {
    logic [4:0] keys;
    int         cycles;
    int         expValids;
    logic [2:0] expCode;
    logic       expMulti;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [2:0] lowestIndex(input logic [4:0] v);
    for (int i = 0; i < 5; i++)
      if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelEdge(input logic [4:0] k_in, input logic r);
    logic [4:0] k;
    if (r) begin
      mS1 = '0; mKs = '0; mPrev = '0;
      mRunStart = edgeNo; mRelMark = edgeNo; mSincePress = 0;
      mPhase = 0; eValid = 0; eHeld = 0; eCode = '0; eMulti = 0;
    end else begin
      k = mKs;
      mKs = mS1;
      mS1 = k_in;
      if (k != mPrev) mRunStart = edgeNo;
      mPrev = k;
      eValid = 0;
      case (mPhase)
        0: if (k != 0 && edgeNo - mRunStart == DB) begin
             eValid = 1; eCode = lowestIndex(k); eMulti = ($countones(k) > 1);
             mPhase = 1; mSincePress = 0;
           end
        1: if (k == 0) begin
             mPhase = 2; mRelMark = edgeNo;
           end else begin
             mSincePress++;
             if (AR && mSincePress >= RD && (mSincePress - RD) % RP == 0) eValid = 1;
           end
        default: if (k != 0) mRelMark = edgeNo;
                 else if (edgeNo - mRelMark == DB) mPhase = 0;
      endcase
      eHeld = (mPhase != 0);
    end
  endtask

  task automatic checkOutput();
    check($sformatf("valid@%0d", edgeNo), bus.valid, eValid);
    check($sformatf("held@%0d", edgeNo), bus.held, eHeld);
    check($sformatf("code@%0d", edgeNo), bus.code, eCode);
    check($sformatf("multi@%0d", edgeNo), bus.multi, eMulti);
    check($sformatf("validTwice@%0d", edgeNo), bus.valid & prevValid, 0);
    prevValid = bus.valid;
  endtask

  task automatic applyStimulus(input logic [4:0] k, input logic r);
    bus.keys = k;
    rst = r;
    @(posedge clk);
    modelEdge(k, r);
    #1;
    checkOutput();
    edgeNo++;
  endtask

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) applyStimulus(5'b0, 1'b0);
  endtask

  int nV, vAt, hAt;
  int vq[$];
  int expQ[$];

  initial begin
    vecs[0] = '{5'b00001, 12, 1, 3'd0, 1'b0};
    vecs[1] = '{5'b00010, 12, 1, 3'd1, 1'b0};
    vecs[2] = '{5'b01000, 12, 1, 3'd3, 1'b0};
    vecs[3] = '{5'b10000, 12, 1, 3'd4, 1'b0};
    vecs[4] = '{5'b10100, 12, 1, 3'd2, 1'b1};
    vecs[5] = '{5'b11111, 12, 1, 3'd0, 1'b1};
    vecs[6] = '{5'b00110,  5, 1, 3'd1, 1'b1};
    vecs[7] = '{5'b01000,  4, 0, 3'd0, 1'b0};
    vecs[8] = '{5'b10010,  2, 0, 3'd0, 1'b0};

    bus.keys = '0; rst = 1'b1; prevValid = 1'b0;
    modelEdge(5'b0, 1'b1);
    applyStimulus(5'b0, 1'b1);
    applyStimulus(5'b0, 1'b1);
    check("resetValid", bus.valid, 0);
    check("resetHeld", bus.held, 0);
    check("resetCode", bus.code, 0);
    check("resetMulti", bus.multi, 0);
    idleGap(3);

    foreach (vecs[v]) begin
      nV = 0;
      for (int i = 0; i < vecs[v].cycles; i++) begin
        applyStimulus(vecs[v].keys, 1'b0);
        if (bus.valid) nV++;
      end
      for (int i = 0; i < 12; i++) begin
        applyStimulus(5'b0, 1'b0);
        if (bus.valid) nV++;
      end
      check($sformatf("vec%0d.valids", v), nV, vecs[v].expValids);
      if (vecs[v].expValids > 0) begin
        check($sformatf("vec%0d.code", v), bus.code, vecs[v].expCode);
        check($sformatf("vec%0d.multi", v), bus.multi, vecs[v].expMulti);
      end
    end

    // Clean press with exact latency for valid, held rise and held fall.
    nV = 0; vAt = -1; hAt = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(5'b00100, 1'b0);
      if (bus.valid) begin nV++; if (vAt < 0) vAt = i; end
      if (bus.held && hAt < 0) hAt = i;
    end
    check("clean.validAt", vAt, 6);
    check("clean.heldAt", hAt, 6);
    check("clean.valids", nV, AR ? 3 : 1);
    check("clean.code", bus.code, 2);
    check("clean.multi", bus.multi, 0);
    hAt = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(5'b0, 1'b0);
      if (!bus.held && hAt < 0) hAt = i;
    end
    check("clean.heldFall", hAt, 6);

    // Bounce on key 0; valid only once the level settles.
    nV = 0; vAt = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i < 10 && (i / 2) % 2 == 1) ? 5'b0 : 5'b00001, 1'b0);
      if (bus.valid) begin nV++; if (vAt < 0) vAt = i; end
    end
    check("bounce.validAt", vAt, 14);
    check("bounce.valids", nV, 1);
    check("bounce.code", bus.code, 0);
    idleGap(12);

    // Chord, then a key change while held must not re-encode.
    nV = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'b11000, 1'b0);
      if (bus.valid) nV++;
    end
    check("multi.valids", nV, 1);
    check("multi.code", bus.code, 3);
    check("multi.multi", bus.multi, 1);
    nV = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'b01000, 1'b0);
      if (bus.valid) nV++;
    end
    check("multi.noReencode", nV, 0);
    check("multi.codeKept", bus.code, 3);
    check("multi.multiKept", bus.multi, 1);
    idleGap(12);

    // Reset in the middle of debouncing discards the press.
    nV = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'b00010, 1'b0);
      if (bus.valid) nV++;
    end
    applyStimulus(5'b00010, 1'b1);
    check("rstMid.valids", nV, 0);
    check("rstMid.valid", bus.valid, 0);
    check("rstMid.held", bus.held, 0);
    check("rstMid.code", bus.code, 0);
    check("rstMid.multi", bus.multi, 0);
    nV = 0; vAt = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'b00010, 1'b0);
      if (bus.valid) begin nV++; if (vAt < 0) vAt = i; end
    end
    check("rstMid.freshAt", vAt, 6);
    check("rstMid.freshCode", bus.code, 1);
    idleGap(12);

    // Release bounce keeps held high until four settled zero samples.
    for (int i = 0; i < 8; i++) applyStimulus(5'b00001, 1'b0);
    nV = 0; hAt = -1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus((i == 2) ? 5'b00001 : 5'b0, 1'b0);
      if (bus.valid) nV++;
      if (!bus.held && hAt < 0) hAt = i;
    end
    check("relBounce.heldFall", hAt, 8);
    check("relBounce.valids", nV, 0);

    // Long hold: one valid, or the repeat train when auto-repeat is built in.
    vq.delete(); expQ.delete();
    expQ.push_back(6);
    if (AR) begin
      expQ.push_back(16); expQ.push_back(19); expQ.push_back(22);
      expQ.push_back(25); expQ.push_back(28);
    end
    for (int i = 0; i < 30; i++) begin
      applyStimulus(5'b10000, 1'b0);
      if (bus.valid) vq.push_back(i);
    end
    check("hold.valids", vq.size(), expQ.size());
    foreach (expQ[j])
      if (j < vq.size()) check($sformatf("hold.valid%0d", j), vq[j], expQ[j]);
    check("hold.code", bus.code, 4);
    idleGap(12);

    // Random key activity with occasional resets, checked every cycle.
    for (int s = 0; s < 300; s++) begin
      logic [4:0] k;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) k = '0;
      else if (sel == 1) k = 5'(1 << $urandom_range(0, 4));
      else k = 5'($urandom);
      if ($urandom_range(0, 39) == 0) applyStimulus(k, 1'b1);
      for (int i = 0; i < int'($urandom_range(1, 14)); i++) applyStimulus(k, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
